// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute result, runs a single-outstanding
// req/ack data-memory handshake for loads/stores, and emits a registered write-back bundle.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_write_reg,
  input  logic              ex_mem_to_reg,
  input  logic              ex_write_mem,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_W-1:0]  e_des_r,
  input  logic [DATA_W-1:0] write_mem_val,
  input  logic              flush,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_write_reg,
  output logic [REG_W-1:0]  wb_des_r,
  output logic [DATA_W-1:0] wb_data,
  output logic              addr_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;

  logic              s_valid, s_write_reg, s_mem_to_reg, s_write_mem, s_kill;
  logic [DATA_W-1:0] s_addr, s_wdata;
  logic [REG_W-1:0]  s_des;

  logic ex_mem, ex_misal, cap_valid, capture, complete, wb_load;

  assign ex_mem    = ex_write_mem | ex_mem_to_reg;
  assign ex_misal  = ex_valid & ex_mem & (alu_result[1:0] != 2'b00);
  // Misaligned memory ops are dropped at capture and never occupy the stage.
  assign cap_valid = ex_valid & ~flush & ~ex_misal;
  assign capture   = ~mem_stall;
  // Non-memory ops complete the cycle after capture; memory ops on their ack.
  assign complete  = s_valid & ((state == IDLE) | dmem_ack);
  assign wb_load   = complete & ~s_kill & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_stall  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (state == ACCESS) begin
      mem_stall  = ~dmem_ack;
      dmem_req   = 1'b1;
      dmem_we    = s_write_mem;
      dmem_addr  = {s_addr[DATA_W-1:2], 2'b00};
      dmem_wdata = s_wdata;
    end
    if (capture) state_nxt = (cap_valid & ex_mem) ? ACCESS : IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid      <= 1'b0;
      s_write_reg  <= 1'b0;
      s_mem_to_reg <= 1'b0;
      s_write_mem  <= 1'b0;
      s_addr       <= '0;
      s_wdata      <= '0;
      s_des        <= '0;
      s_kill       <= 1'b0;
    end else if (capture) begin
      s_valid      <= cap_valid;
      s_write_reg  <= ex_write_reg;
      s_mem_to_reg <= ex_mem_to_reg;
      s_write_mem  <= ex_write_mem;
      s_addr       <= alu_result;
      s_wdata      <= write_mem_val;
      s_des        <= e_des_r;
      s_kill       <= 1'b0;
    end else if (flush) begin
      // The handshake must still finish; only the write-back is suppressed.
      s_kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_write_reg <= 1'b0;
      wb_des_r     <= '0;
      wb_data      <= '0;
    end else begin
      wb_valid <= wb_load;
      if (wb_load) begin
        wb_write_reg <= s_write_reg;
        wb_des_r     <= s_des;
        wb_data      <= s_mem_to_reg ? dmem_rdata : s_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                addr_err <= 1'b0;
    else if (capture & ex_misal & ~flush)    addr_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random load/store/ALU traffic checked
// against an in-order write-back scoreboard and a word-array memory model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_write_reg, ex_mem_to_reg, ex_write_mem, flush;
  logic [31:0] alu_result, write_mem_val;
  logic [4:0]  e_des_r;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_write_reg, addr_err;
  logic [4:0]  wb_des_r;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_write_reg(ex_write_reg), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_write_mem(ex_write_mem), .alu_result(alu_result), .e_des_r(e_des_r),
    .write_mem_val(write_mem_val), .flush(flush), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_write_reg(wb_write_reg), .wb_des_r(wb_des_r), .wb_data(wb_data), .addr_err(addr_err)
  );

  typedef struct packed { logic wr; logic [4:0] des; logic [31:0] data; } wb_t;

  wb_t         expq[$];
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          errors = 0, checks = 0;
  bit          exp_err = 1'b0;
  int          req_cnt = 0, stall_cnt = 0, wb_cnt = 0;
  int          fixed_wait = 0;
  bit          busy = 1'b0;
  int          wcnt = 0, wtgt = 0;

  // Memory responder: ack after wtgt wait cycles; random ack noise while idle.
  always @(negedge clk) begin
    if (dmem_req === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = 0;
        wtgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
      end
      if (wcnt == wtgt) begin
        dmem_ack   = 1'b1;
        dmem_rdata = mem[dmem_addr[9:2]];
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      busy       = 1'b0;
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    if (dmem_req === 1'b1 && dmem_ack === 1'b1) begin
      if (dmem_we) mem[dmem_addr[9:2]] = dmem_wdata;
      busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    wb_t e;
    @(negedge clk); #1;
    if (dmem_req === 1'b1)  req_cnt++;
    if (mem_stall === 1'b1) stall_cnt++;
    if (wb_valid === 1'b1) begin
      wb_cnt++;
      if (expq.size() == 0) chk("wb_valid_unexpected", wb_valid, 32'd0);
      else begin
        e = expq.pop_front();
        chk("wb_write_reg", wb_write_reg, e.wr);
        chk("wb_des_r", wb_des_r, e.des);
        chk("wb_data", wb_data, e.data);
      end
    end
    chk("addr_err", addr_err, exp_err);
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0;
    repeat (n) step();
  endtask

  // Present one op, wait out any stall, record its expected outcome, cross the capture edge.
  task automatic issue(input bit ld, input bit st, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] des, input bit exp_wb);
    int n = 0;
    ex_valid = 1'b1; ex_mem_to_reg = ld; ex_write_mem = st; ex_write_reg = wr;
    alu_result = addr; write_mem_val = wdata; e_des_r = des;
    while (mem_stall === 1'b1 && n < 64) begin step(); n++; end
    if (n >= 64) chk("stall_timeout", mem_stall, 32'd0);
    if ((ld || st) && addr[1:0] != 2'b00) exp_err = 1'b1;
    else begin
      if (st) ref_mem[addr[9:2]] = wdata;
      if (exp_wb) expq.push_back('{wr, des, (ld ? ref_mem[addr[9:2]] : addr)});
    end
    step();
    ex_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int r, w0, mism;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = mem[i];
    end
    mem[8'h40] = 32'hDEAD_BEEF; ref_mem[8'h40] = 32'hDEAD_BEEF;
    rst = 1'b0; ex_valid = 0; ex_write_reg = 0; ex_mem_to_reg = 0; ex_write_mem = 0;
    alu_result = 0; write_mem_val = 0; e_des_r = 0; flush = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_write_reg", wb_write_reg, 0);
    chk("rst_wb_des_r", wb_des_r, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_addr_err", addr_err, 0);
    rst = 1'b1;
    idle(2);

    // ALU op: write-back one cycle after capture, no stall.
    stall_cnt = 0;
    issue(0, 0, 1, 32'h1234, 0, 5'd3, 1);
    chk("alu_wb_early", wb_valid, 0);
    step();
    chk("alu_wb_valid", wb_valid, 1);
    idle(2);
    chk("alu_no_stall", stall_cnt, 0);

    // Load with two wait cycles.
    fixed_wait = 2; req_cnt = 0; stall_cnt = 0;
    issue(1, 0, 1, 32'h100, 0, 5'd7, 1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", dmem_we, 0);
    idle(4);
    chk("ld_req_cycles", req_cnt, 3);
    chk("ld_stall_cycles", stall_cnt, 2);

    // Zero-wait store immediately followed by a load.
    fixed_wait = 0;
    issue(0, 1, 0, 32'h40, 32'hA5A5_A5A5, 5'd4, 1);
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h40);
    chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
    issue(1, 0, 1, 32'h44, 0, 5'd5, 1);
    chk("b2b_req", dmem_req, 1);
    chk("b2b_we", dmem_we, 0);
    chk("b2b_addr", dmem_addr, 32'h44);
    chk("b2b_wb_store", wb_valid, 1);
    step();
    chk("b2b_wb_load", wb_valid, 1);
    idle(2);

    // Misaligned load is dropped and latches addr_err.
    req_cnt = 0; w0 = wb_cnt;
    issue(1, 0, 1, 32'h102, 0, 5'd9, 0);
    idle(3);
    chk("mis_no_req", req_cnt, 0);
    chk("mis_no_wb", wb_cnt - w0, 0);

    // Flush during a load wait: handshake completes, no write-back.
    fixed_wait = 3; req_cnt = 0; w0 = wb_cnt;
    issue(1, 0, 1, 32'h200, 0, 5'd10, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(5);
    chk("flush_req_cycles", req_cnt, 4);
    chk("flush_no_wb", wb_cnt - w0, 0);
    issue(0, 0, 1, 32'h55, 0, 5'd11, 1);
    idle(2);

    // Reset while a request is outstanding.
    fixed_wait = 5;
    issue(1, 0, 1, 32'h300, 0, 5'd12, 0);
    chk("pre_rst_req", dmem_req, 1);
    rst = 1'b0; exp_err = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", mem_stall, 0);
    chk("mid_rst_wb", wb_valid, 0);
    chk("mid_rst_addr_err", addr_err, 0);
    idle(2);
    rst = 1'b1; req_cnt = 0; w0 = wb_cnt;
    idle(3);
    chk("post_rst_req", req_cnt, 0);
    chk("post_rst_wb", wb_cnt - w0, 0);

    // Random traffic with random memory latency.
    fixed_wait = -1;
    repeat (300) begin
      r = $urandom_range(0, 99);
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (r < 40)      issue(0, 0, 1'($urandom), $urandom, $urandom, 5'($urandom), 1);
      else if (r < 65) issue(1, 0, 1, a, $urandom, 5'($urandom), 1);
      else if (r < 90) issue(0, 1, 0, a, $urandom, 5'($urandom), 1);
      else begin
        a[1:0] = 2'($urandom_range(1, 3));
        if (r < 95) issue(1, 0, 1, a, $urandom, 5'($urandom), 0);
        else        issue(0, 1, 0, a, $urandom, 5'($urandom), 0);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(10);
    chk("scoreboard_drained", expq.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("memory_contents", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits directly downstream of the execute stage. It registers the execute result, drives a single-outstanding request/acknowledge data-memory port for loads and stores, and stalls upstream while a memory access is pending. It then presents a registered write-back bundle to the write-back stage.

## Interface
Parameters:
- DATA_W, 32, data and address width
- REG_W, 5, destination register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- ex_valid  in  1  execute stage holds a valid instruction
- ex_write_reg  in  1  instruction writes a register
- ex_mem_to_reg  in  1  instruction is a load
- ex_write_mem  in  1  instruction is a store
- alu_result  in  DATA_W  ALU result; used as the memory byte address for loads and stores
- e_des_r  in  REG_W  destination register index
- write_mem_val  in  DATA_W  store data
- flush  in  1  kill the instruction held in this stage
- mem_stall  out  1  upstream must hold its outputs this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DATA_W  word-aligned byte address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- wb_valid  out  1  write-back bundle valid (one-cycle pulse per instruction)
- wb_write_reg  out  1  register write enable
- wb_des_r  out  REG_W  destination index
- wb_data  out  DATA_W  ALU result or load data
- addr_err  out  1  sticky; a misaligned load or store was dropped

## Operation
- Stage register fields: valid, write_reg, mem_to_reg, write_mem, addr, wdata, des, kill.
- FSM states:
  - IDLE: stage register is empty or holds a non-memory op.
  - ACCESS: a memory request is outstanding.
- Capture: on each rising edge with mem_stall=0, the stage register loads the execute outputs. A non-valid input loads a bubble.
- Entry into ACCESS: the captured op is valid, is a load or store, and alu_result[1:0]==0. Otherwise the FSM stays in IDLE.
- Misaligned load or store:
  - No request is issued and no write-back occurs (wb_valid stays 0).
  - addr_err is set and stays set until reset.
- In ACCESS:
  - dmem_req=1.
  - dmem_we, dmem_addr and dmem_wdata come from the stage register and are held stable until the ack.
- mem_stall = (state==ACCESS) && !dmem_ack. The ack cycle releases the stall, so the next op is captured on the ack edge.
- Completion:
  - Non-memory op: completes in the cycle after capture.
  - Memory op: completes on the edge where dmem_ack=1.
  - On completion the FSM leaves ACCESS, unless the newly captured op is itself a memory op (back-to-back accesses stay in ACCESS).
- Write-back registers, loaded at completion unless kill is set:
  - wb_valid=1
  - wb_write_reg = write_reg
  - wb_des_r = des
  - wb_data = dmem_rdata for loads, addr (the ALU result) otherwise
  - Stores set wb_valid=1 with wb_write_reg=0.
- flush:
  - In IDLE: the stage register becomes a bubble at the next edge.
  - In ACCESS: sets kill. The handshake still runs to its ack; the store is still performed but no write-back occurs.
- dmem_ack while not in ACCESS is ignored.

## Timing
- Reset values:
  - FSM = IDLE; stage register valid = 0, kill = 0
  - mem_stall = 0, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0
  - wb_valid = 0, wb_write_reg = 0, wb_des_r = 0, wb_data = 0
  - addr_err = 0
- Reset mid-access drops the request immediately; no write-back follows.
- ALU op captured at edge N: wb_valid is high for cycle N+1 to N+2.
- Memory op captured at edge N, with ack after k wait cycles (k ≥ 0): dmem_req is high from N to N+1+k, and wb_valid is high after edge N+1+k. With k=0 the latency matches an ALU op.
- mem_stall is combinational from state and dmem_ack. All other outputs are registered, except that dmem_* are decoded from registered state.
- Sustained throughput is one instruction per cycle with a zero-wait memory.

## Test plan
- ALU op: alu_result=0x1234, e_des_r=3, write_reg=1 → one cycle later wb_valid=1, wb_des_r=3, wb_data=0x1234; mem_stall never asserted.
- Load at 0x100 with ack after 2 waits, rdata=0xDEADBEEF → req held 3 cycles, mem_stall high for 2 cycles, then wb_data=0xDEADBEEF with wb_write_reg=1.
- Store at 0x40 with wdata=0xA5A5A5A5, zero-wait, followed immediately by a load at 0x44 → req stays high across both, dmem_we goes 1 then 0, and the two wb_valid pulses come in consecutive cycles.
- Load at address 0x102 → no dmem_req, no wb_valid, addr_err=1 and stays 1.
- flush asserted during the wait of a load at 0x200 → req held until ack, no wb_valid; the next ALU op then writes back normally.
- rst driven low while req is pending → dmem_req, mem_stall and wb_valid go 0 immediately and stay 0 until new input arrives.
